// File: rtl/aes_uart_rx_framer.sv
// Command-frame parser between the UART receiver and the AES core: a K/E/D byte plus 16 payload bytes
// yields one strobe with a 128-bit payload. Optional inter-byte timeout enabled by AES_RX_TIMEOUT_EN.
module aes_uart_rx_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  CMD_KEY        = 8'h4B,
  parameter logic [7:0]  CMD_ENC        = 8'h45,
  parameter logic [7:0]  CMD_DEC        = 8'h44
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         load_new_key,
  output logic [127:0] cipher_key,
  output logic         enc_in_valid,
  output logic         dec_in_valid,
  output logic [127:0] block_data,
  output logic         frame_err,
  output logic         timeout_err,
  output logic         rx_idle
);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

  state_t       state_reg, state_next;
  logic [3:0]   byte_cnt_reg, byte_cnt_next;
  logic [7:0]   cmd_reg, cmd_next;
  logic [127:0] shreg_reg, shreg_next;
  logic [127:0] key_reg, key_next;
  logic [127:0] blk_reg, blk_next;
  logic         lk_reg, lk_next;
  logic         enc_reg, enc_next;
  logic         dec_reg, dec_next;
  logic         ferr_reg, ferr_next;
  logic         to_reg, to_next;
`ifdef AES_RX_TIMEOUT_EN
  logic [31:0]  idle_cnt_reg, idle_cnt_next;
`endif

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    cmd_next      = cmd_reg;
    shreg_next    = shreg_reg;
    key_next      = key_reg;
    blk_next      = blk_reg;
    lk_next       = 1'b0;
    enc_next      = 1'b0;
    dec_next      = 1'b0;
    ferr_next     = 1'b0;
    to_next       = 1'b0;
`ifdef AES_RX_TIMEOUT_EN
    idle_cnt_next = idle_cnt_reg;
`endif
    case (state_reg)
      // ISSUE behaves like IDLE for incoming bytes so back-to-back frames lose nothing
      IDLE, ISSUE: begin
        state_next = IDLE;
        if (rx_valid) begin
          if (rx_data == CMD_KEY || rx_data == CMD_ENC || rx_data == CMD_DEC) begin
            cmd_next      = rx_data;
            byte_cnt_next = 4'd0;
            state_next    = COLLECT;
`ifdef AES_RX_TIMEOUT_EN
            idle_cnt_next = 32'd0;
`endif
          end else begin
            ferr_next = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          shreg_next    = {shreg_reg[119:0], rx_data};
          byte_cnt_next = byte_cnt_reg + 4'd1;
`ifdef AES_RX_TIMEOUT_EN
          idle_cnt_next = 32'd0;
`endif
          if (byte_cnt_reg == 4'd15) begin
            state_next    = ISSUE;
            byte_cnt_next = 4'd0;
            case (cmd_reg)
              CMD_KEY: begin key_next = shreg_next; lk_next  = 1'b1; end
              CMD_ENC: begin blk_next = shreg_next; enc_next = 1'b1; end
              CMD_DEC: begin blk_next = shreg_next; dec_next = 1'b1; end
              default: ;
            endcase
          end
        end
`ifdef AES_RX_TIMEOUT_EN
        else if (idle_cnt_reg == 32'(TIMEOUT_CYCLES - 1)) begin
          to_next       = 1'b1;
          state_next    = IDLE;
          byte_cnt_next = 4'd0;
        end else begin
          idle_cnt_next = idle_cnt_reg + 32'd1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= 4'd0;
      cmd_reg      <= 8'd0;
      shreg_reg    <= '0;
      key_reg      <= '0;
      blk_reg      <= '0;
      lk_reg       <= 1'b0;
      enc_reg      <= 1'b0;
      dec_reg      <= 1'b0;
      ferr_reg     <= 1'b0;
      to_reg       <= 1'b0;
`ifdef AES_RX_TIMEOUT_EN
      idle_cnt_reg <= 32'd0;
`endif
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      cmd_reg      <= cmd_next;
      shreg_reg    <= shreg_next;
      key_reg      <= key_next;
      blk_reg      <= blk_next;
      lk_reg       <= lk_next;
      enc_reg      <= enc_next;
      dec_reg      <= dec_next;
      ferr_reg     <= ferr_next;
      to_reg       <= to_next;
`ifdef AES_RX_TIMEOUT_EN
      idle_cnt_reg <= idle_cnt_next;
`endif
    end
  end

  assign load_new_key = lk_reg;
  assign cipher_key   = key_reg;
  assign enc_in_valid = enc_reg;
  assign dec_in_valid = dec_reg;
  assign block_data   = blk_reg;
  assign frame_err    = ferr_reg;
  assign timeout_err  = to_reg;
  assign rx_idle      = (state_reg == IDLE);

endmodule

// File: tb/tb_aes_uart_rx_framer.sv
// Self-checking bench for aes_uart_rx_framer: frame-level reference model compared every cycle,
// directed frames with literal expectations, then randomized frames, gaps, junk bytes and resets.
module tb_aes_uart_rx_framer;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'd0;
  logic         load_new_key, enc_in_valid, dec_in_valid, frame_err, timeout_err, rx_idle;
  logic [127:0] cipher_key, block_data;

  aes_uart_rx_framer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .load_new_key(load_new_key), .cipher_key(cipher_key),
    .enc_in_valid(enc_in_valid), .dec_in_valid(dec_in_valid), .block_data(block_data),
    .frame_err(frame_err), .timeout_err(timeout_err), .rx_idle(rx_idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cnt_lk = 0, cnt_enc = 0, cnt_dec = 0, cnt_ferr = 0, cnt_to = 0;

  // Frame-level model: a list of payload bytes collected so far for the open frame
  bit           m_in_frame = 0;
  logic [7:0]   m_cmd = 8'd0;
  logic [7:0]   m_bytes [16];
  int           m_n = 0;
  int           m_idle = 0;
  logic [127:0] e_key = '0, e_blk = '0;
  bit           e_lk = 0, e_enc = 0, e_dec = 0, e_ferr = 0, e_to = 0, e_idle = 1;

  function automatic bit is_cmd(input logic [7:0] b);
    return b == 8'h4B || b == 8'h45 || b == 8'h44;
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_cmd = 8'd0; m_n = 0; m_idle = 0;
    e_key = '0; e_blk = '0;
    e_lk = 0; e_enc = 0; e_dec = 0; e_ferr = 0; e_to = 0; e_idle = 1;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    logic [127:0] val;
    bit issued;
    issued = 0;
    e_lk = 0; e_enc = 0; e_dec = 0; e_ferr = 0; e_to = 0;
    if (m_in_frame) begin
      if (v) begin
        m_bytes[m_n] = d;
        m_n++;
        m_idle = 0;
        if (m_n == 16) begin
          for (int i = 0; i < 16; i++) val[127 - 8*i -: 8] = m_bytes[i];
          if (m_cmd == 8'h4B) begin e_key = val; e_lk = 1; end
          else if (m_cmd == 8'h45) begin e_blk = val; e_enc = 1; end
          else begin e_blk = val; e_dec = 1; end
          m_in_frame = 0;
          issued = 1;
        end
      end else begin
`ifdef AES_RX_TIMEOUT_EN
        if (m_idle == TO - 1) begin
          e_to = 1;
          m_in_frame = 0;
        end else begin
          m_idle++;
        end
`endif
      end
    end else if (v) begin
      if (is_cmd(d)) begin
        m_in_frame = 1; m_cmd = d; m_n = 0; m_idle = 0;
      end else begin
        e_ferr = 1;
      end
    end
    e_idle = !m_in_frame && !issued;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(rx_valid, rx_data);
  end

  initial forever begin
    @(negedge clk);
    cnt_lk   += int'(load_new_key);
    cnt_enc  += int'(enc_in_valid);
    cnt_dec  += int'(dec_in_valid);
    cnt_ferr += int'(frame_err);
    cnt_to   += int'(timeout_err);
    if (!rst_n) begin
      chk("rst_pulses", {load_new_key, enc_in_valid, dec_in_valid, frame_err, timeout_err}, 5'b0);
      chk("rst_key", cipher_key, 128'd0);
      chk("rst_blk", block_data, 128'd0);
      chk("rst_idle", rx_idle, 1'b1);
    end else begin
      chk("load_new_key", load_new_key, e_lk);
      chk("enc_in_valid", enc_in_valid, e_enc);
      chk("dec_in_valid", dec_in_valid, e_dec);
      chk("frame_err", frame_err, e_ferr);
      chk("timeout_err", timeout_err, e_to);
      chk("rx_idle", rx_idle, e_idle);
      chk("cipher_key", cipher_key, e_key);
      chk("block_data", block_data, e_blk);
    end
  end

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_idle", rx_idle, 1'b1);
    chk("async_rst_key", cipher_key, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lk0, enc0, dec0, ferr0, to0;
    int r, k;
    logic [7:0] c;

    @(posedge clk); #1;
    chk("reset_idle", rx_idle, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(2);

    // T1 key frame
    lk0 = cnt_lk; enc0 = cnt_enc; dec0 = cnt_dec;
    put(8'h4B);
    for (int i = 0; i < 16; i++) put(8'(i));
    chk("t1_strobe", load_new_key, 1'b1);
    chk("t1_key", cipher_key, 128'h000102030405060708090a0b0c0d0e0f);
    gap(2);
    chk("t1_one_pulse", 32'(cnt_lk - lk0), 32'd1);
    chk("t1_no_encdec", 32'(cnt_enc + cnt_dec - enc0 - dec0), 32'd0);

    // T2 encrypt frame
    put(8'h45);
    for (int i = 0; i < 16; i++) put(8'(i * 8'h11));
    chk("t2_strobe", enc_in_valid, 1'b1);
    chk("t2_blk", block_data, 128'h00112233445566778899aabbccddeeff);
    chk("t2_key_kept", cipher_key, 128'h000102030405060708090a0b0c0d0e0f);
    gap(2);

    // T3 bad command then decrypt frame
    ferr0 = cnt_ferr;
    put(8'h41);
    chk("t3_ferr", frame_err, 1'b1);
    put(8'h44);
    for (int i = 0; i < 16; i++) put(8'hC0 + 8'(i));
    chk("t3_dec", dec_in_valid, 1'b1);
    chk("t3_blk", block_data, 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
    gap(2);
    chk("t3_ferr_count", 32'(cnt_ferr - ferr0), 32'd1);

    // T4 back-to-back E then D frames
    put(8'h45);
    for (int i = 0; i < 16; i++) put(8'hA0 + 8'(i));
    chk("t4_enc_cyc18", enc_in_valid, 1'b1);
    chk("t4_enc_blk", block_data, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
    put(8'h44);
    for (int i = 0; i < 16; i++) put(8'h50 + 8'(i));
    chk("t4_dec_cyc35", dec_in_valid, 1'b1);
    chk("t4_dec_blk", block_data, 128'h505152535455565758595a5b5c5d5e5f);
    gap(2);

    // T5 reset mid-frame
    put(8'h45);
    for (int i = 0; i < 7; i++) put(8'($urandom));
    do_reset();
    gap(1);
    put(8'h4B);
    for (int i = 0; i < 16; i++) put(8'hF0 + 8'(i));
    chk("t5_key", cipher_key, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    gap(2);

    // T6 timeout
    enc0 = cnt_enc; to0 = cnt_to;
    put(8'h45);
    for (int i = 0; i < 5; i++) put(8'($urandom));
    gap(TO);
`ifdef AES_RX_TIMEOUT_EN
    chk("t6_timeout_pulse", timeout_err, 1'b1);
    gap(2);
    chk("t6_to_count", 32'(cnt_to - to0), 32'd1);
    chk("t6_idle_after", rx_idle, 1'b1);
`else
    gap(2);
    chk("t6_no_timeout", 32'(cnt_to - to0), 32'd0);
    chk("t6_stays_collect", rx_idle, 1'b0);
`endif
    chk("t6_no_enc", 32'(cnt_enc - enc0), 32'd0);
    do_reset();
    gap(1);

    // Randomized frames, junk bytes, gaps and occasional mid-frame resets
    repeat (150) begin
      r = $urandom_range(0, 19);
      if (r < 2) begin
        c = 8'($urandom);
        if (is_cmd(c)) c = 8'h00;
        put(c);
      end else begin
        k = $urandom_range(0, 2);
        c = (k == 0) ? 8'h4B : (k == 1) ? 8'h45 : 8'h44;
        put(c);
        for (int i = 0; i < 16; i++) begin
          if (r == 19 && i == 9) begin
            do_reset();
            break;
          end
          put(8'($urandom));
          if ($urandom_range(0, 7) == 0) gap($urandom_range(1, 3));
        end
      end
      if ($urandom_range(0, 1) == 1) gap($urandom_range(0, 3));
    end
    gap(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
